// File: rtl/gpu_ram_rr_arbiter.sv
// rtl/gpu_ram_rr_arbiter.sv - round-robin GPU RAM port arbiter with burst lock and read-return routing
module gpu_ram_rr_arbiter #(
  parameter int N_PORTS           = 4,
  parameter int READ_CLOCK_CYCLES = 2,
  parameter int MAX_BURST         = 4,
  parameter int ADDR_W            = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_PORTS-1:0]      req_valid,
  output logic [N_PORTS-1:0]      req_ready,
  input  logic [N_PORTS-1:0]      req_wr,
  input  logic [N_PORTS-1:0]      req_16bit,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*16-1:0]   req_data,
  output logic                    ram_wr_ena,
  output logic                    ram_rd_req,
  output logic                    ram_ena_16bit,
  output logic [ADDR_W-1:0]       ram_address,
  output logic [15:0]             ram_data_out,
  input  logic [15:0]             ram_data_in,
  output logic [N_PORTS-1:0]      rd_rdy,
  output logic [15:0]             rd_data
);

  localparam int IW = $clog2(N_PORTS);
  localparam int CW = 4;
  localparam int RD = READ_CLOCK_CYCLES;

  logic [IW-1:0]     last_grant;
  logic [CW-1:0]     burst_cnt;
  logic              grant_any;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     cand [N_PORTS];
  logic [ADDR_W-1:0] addr_arr [N_PORTS];
  logic [15:0]       data_arr [N_PORTS];

  logic [RD-1:0]         pipe_vld;
  logic [RD-1:0][IW-1:0] pipe_port;

  // cand[k] is the (k+1)-th port after last_grant, wrapping; the last entry is last_grant itself
  for (genvar k = 1; k <= N_PORTS; k++) begin : g_cand
    logic [IW:0] sum;
    assign sum = {1'b0, last_grant} + (IW+1)'(k);
    assign cand[k-1] = (sum >= (IW+1)'(N_PORTS)) ? IW'(sum - (IW+1)'(N_PORTS)) : IW'(sum);
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = req_data[i*16 +: 16];
  end

  // burst_cnt==0 means the previous cycle was idle, so the lock only holds during an active stream
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_grant;
    if (burst_cnt != '0 && burst_cnt < CW'(MAX_BURST) && req_valid[last_grant]) begin
      grant_any = 1'b1;
    end else begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (!grant_any && req_valid[cand[k]]) begin
          grant_any = 1'b1;
          grant_idx = cand[k];
        end
      end
    end
  end

  assign req_ready = grant_any ? (N_PORTS'(1) << grant_idx) : '0;
  assign rd_data   = ram_data_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant    <= IW'(N_PORTS - 1);
      burst_cnt     <= '0;
      ram_wr_ena    <= 1'b0;
      ram_rd_req    <= 1'b0;
      ram_ena_16bit <= 1'b0;
      ram_address   <= '0;
      ram_data_out  <= '0;
    end else begin
      ram_wr_ena <= 1'b0;
      ram_rd_req <= 1'b0;
      if (grant_any) begin
        last_grant    <= grant_idx;
        ram_wr_ena    <= req_wr[grant_idx];
        ram_rd_req    <= !req_wr[grant_idx];
        ram_ena_16bit <= req_16bit[grant_idx];
        ram_address   <= addr_arr[grant_idx];
        ram_data_out  <= data_arr[grant_idx];
        if (grant_idx == last_grant)
          burst_cnt <= (burst_cnt >= CW'(MAX_BURST)) ? burst_cnt : burst_cnt + CW'(1);
        else
          burst_cnt <= CW'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // Stage 0 is written on the same edge that raises ram_rd_req; rd_rdy is registered off the last stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld  <= '0;
      pipe_port <= '0;
      rd_rdy    <= '0;
    end else begin
      pipe_vld[0]  <= grant_any && !req_wr[grant_idx];
      pipe_port[0] <= grant_idx;
      for (int k = 1; k < RD; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_port[k] <= pipe_port[k-1];
      end
      rd_rdy <= pipe_vld[RD-1] ? (N_PORTS'(1) << pipe_port[RD-1]) : '0;
    end
  end

endmodule

// File: tb/tb_gpu_ram_rr_arbiter.sv
// tb/tb_gpu_ram_rr_arbiter.sv - directed vector bench for gpu_ram_rr_arbiter
module tb_gpu_ram_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_wr;
  logic [3:0]  req_16bit;
  logic [79:0] req_addr;
  logic [63:0] req_data;
  logic        ram_wr_ena;
  logic        ram_rd_req;
  logic        ram_ena_16bit;
  logic [19:0] ram_address;
  logic [15:0] ram_data_out;
  logic [15:0] ram_data_in;
  logic [3:0]  rd_rdy;
  logic [15:0] rd_data;

  int n_vec;
  int n_err;

  gpu_ram_rr_arbiter #(
    .N_PORTS(4), .READ_CLOCK_CYCLES(2), .MAX_BURST(4), .ADDR_W(20)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_16bit(req_16bit), .req_addr(req_addr), .req_data(req_data),
    .ram_wr_ena(ram_wr_ena), .ram_rd_req(ram_rd_req), .ram_ena_16bit(ram_ena_16bit),
    .ram_address(ram_address), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .rd_rdy(rd_rdy), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  wr;
    logic [3:0]  rdy;
    logic        we;
    logic        rd;
    logic        w16;
    logic [19:0] addr;
    logic [15:0] data;
    logic [3:0]  rrdy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ram_wr_ena"}, 32'(ram_wr_ena), 32'd0);
    chk({tag, " ram_rd_req"}, 32'(ram_rd_req), 32'd0);
    chk({tag, " ram_ena_16bit"}, 32'(ram_ena_16bit), 32'd0);
    chk({tag, " ram_address"}, 32'(ram_address), 32'd0);
    chk({tag, " ram_data_out"}, 32'(ram_data_out), 32'd0);
    chk({tag, " rd_rdy"}, 32'(rd_rdy), 32'd0);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
  endtask

  logic [19:0] port_addr [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    port_addr[0] = 20'h00010; port_addr[1] = 20'h00110;
    port_addr[2] = 20'h00210; port_addr[3] = 20'h00310;
    req_addr    = {port_addr[3], port_addr[2], port_addr[1], port_addr[0]};
    req_data    = {16'hBEEF, 16'h2222, 16'h1111, 16'hA0A0};
    req_16bit   = 4'b1000;
    ram_data_in = 16'h5A5A;
    req_valid   = '0;
    req_wr      = '0;
    reset       = 1'b1;

    //           v        wr       rdy      we    rd    w16   addr       data      rrdy
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 20'h00000, 16'h0000, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 20'h00010, 16'hA0A0, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 20'h00010, 16'hA0A0, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 20'h00010, 16'hA0A0, 4'b0001};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 20'h00010, 16'hA0A0, 4'b0000};
    tbl[5]  = '{4'b0010, 4'b1000, 4'b0010, 1'b0, 1'b0, 1'b0, 20'h00010, 16'hA0A0, 4'b0000};
    tbl[6]  = '{4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 20'h00110, 16'h1111, 4'b0000};
    tbl[7]  = '{4'b0010, 4'b1000, 4'b0010, 1'b1, 1'b0, 1'b1, 20'h00310, 16'hBEEF, 4'b0000};
    tbl[8]  = '{4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 20'h00110, 16'h1111, 4'b0010};
    tbl[9]  = '{4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 20'h00310, 16'hBEEF, 4'b0000};
    tbl[10] = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 20'h00310, 16'hBEEF, 4'b0010};
    tbl[11] = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 20'h00310, 16'hBEEF, 4'b0000};
    tbl[12] = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 20'h00310, 16'hBEEF, 4'b0000};
    tbl[13] = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 20'h00310, 16'hBEEF, 4'b0000};
    tbl[14] = '{4'b0000, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 20'h00310, 16'hBEEF, 4'b0000};

    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset rd_data", 32'(rd_data), 32'h5A5A);

    // single read, idle gap, alternating read p1 / write p3, then five idle clocks
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      reset     = 1'b0;
      req_valid = tbl[i].v;
      req_wr    = tbl[i].wr;
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d ram_wr_ena", i), 32'(ram_wr_ena), 32'(tbl[i].we));
      chk($sformatf("row%0d ram_rd_req", i), 32'(ram_rd_req), 32'(tbl[i].rd));
      chk($sformatf("row%0d ram_ena_16bit", i), 32'(ram_ena_16bit), 32'(tbl[i].w16));
      chk($sformatf("row%0d ram_address", i), 32'(ram_address), 32'(tbl[i].addr));
      chk($sformatf("row%0d ram_data_out", i), 32'(ram_data_out), 32'(tbl[i].data));
      chk($sformatf("row%0d rd_rdy", i), 32'(rd_rdy), 32'(tbl[i].rrdy));
    end

    // all four ports streaming writes; after idle with last_grant=3 the order restarts at port 0
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      req_valid = 4'b1111;
      req_wr    = 4'b1111;
      #1;
      chk($sformatf("burst%0d req_ready", k), 32'(req_ready), 32'(4'b0001 << ((k / 4) % 4)));
      if (k > 0) begin
        chk($sformatf("burst%0d ram_wr_ena", k), 32'(ram_wr_ena), 32'd1);
        chk($sformatf("burst%0d ram_address", k), 32'(ram_address), 32'(port_addr[((k - 1) / 4) % 4]));
      end
    end

    // port 2 alone: uninterrupted stream beyond MAX_BURST
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_valid = 4'b0100;
      #1;
      chk($sformatf("lone%0d req_ready", k), 32'(req_ready), 32'h4);
      if (k > 0) begin
        chk($sformatf("lone%0d ram_wr_ena", k), 32'(ram_wr_ena), 32'd1);
        chk($sformatf("lone%0d ram_address", k), 32'(ram_address), 32'h00210);
      end
    end
    // port 1 joins while port 2's count is saturated: switches immediately, then port 1 holds
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 4'b0110;
      #1;
      chk($sformatf("join%0d req_ready", k), 32'(req_ready), 32'h2);
    end

    // two reads from port 0, reset lands while both are still in flight
    req_wr = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      chk($sformatf("pre_rst%0d req_ready", k), 32'(req_ready), 32'h1);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    chk("pre_rst ram_rd_req", 32'(ram_rd_req), 32'd1);
    chk("pre_rst ram_address", 32'(ram_address), 32'h00010);
    reset = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("in_rst%0d rd_rdy", k), 32'(rd_rdy), 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk($sformatf("post_rst%0d rd_rdy", k), 32'(rd_rdy), 32'd0);
      chk($sformatf("post_rst%0d ram_rd_req", k), 32'(ram_rd_req), 32'd0);
    end
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("post_rst first grant", 32'(req_ready), 32'h1);

    @(negedge clk);
    req_valid = 4'b0000;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
